contador_seq_ctrl: RTL and testbench
====================================

// Module: contador_seq_ctrl
// PURPOSE
//  Command-driven sequencer for the sync up/down counter (load/count_up/counter_on/Data_in).
//  Accepts LOAD / RUN-UP-N / RUN-DOWN-N commands over a valid/ready handshake.
//  Drives the counter control pins and watches its Count output.
//  Reports completion with a done pulse and a captured final value.
//  Sits between the control plane and one counter instance; only this block drives that counter.
// PARAMETERS
//  NBITS_COUNT  2  counter width; must match the counter instance
//  NBITS_STEPS  4  width of the step-count field; max steps per command = 2**NBITS_STEPS-1
// PORTS
//  clk             in   1            single clock; all state changes on posedge
//  reset           in   1            synchronous, active-high
//  cmd_valid       in   1            command present
//  cmd_ready       out  1            block can accept a command (high only in IDLE)
//  cmd_op          in   2            00 LOAD, 01 RUN_UP, 10 RUN_DOWN, 11 NOP
//  cmd_data        in   NBITS_COUNT  LOAD value
//  cmd_steps       in   NBITS_STEPS  number of counter steps for RUN_UP/RUN_DOWN
//  abort           in   1            terminate the current LOAD/RUN
//  ctr_load        out  1            to counter load
//  ctr_count_up    out  1            to counter count_up
//  ctr_counter_on  out  1            to counter counter_on
//  ctr_data        out  NBITS_COUNT  to counter Data_in
//  ctr_count       in   NBITS_COUNT  from counter Count
//  busy            out  1            high in LOAD, RUN and DONE
//  done            out  1            one-cycle pulse in DONE
//  aborted         out  1            valid with done; 1 if the command was cut short by abort
//  final_count     out  NBITS_COUNT  ctr_count captured on the edge leaving DONE; held until the next capture
// BEHAVIOUR
//  Reset: the edge with reset=1 forces IDLE. All outputs are 0 except cmd_ready=1. final_count=0, aborted=0.
//    Reset mid-command drops all counter controls on the next cycle. The counter keeps its value.
//  FSM has four states: IDLE, LOAD, RUN, DONE. Handshake accept = cmd_valid & cmd_ready (IDLE only).
//    Command fields are latched at accept.
//  IDLE -> LOAD on LOAD.
//  IDLE -> RUN on RUN_UP/RUN_DOWN with steps>0; remaining counter = steps.
//  IDLE -> DONE on NOP, or on RUN_x with steps==0; the counter is never touched.
//  LOAD: ctr_load=1 and ctr_data=latched data for exactly 1 cycle, then DONE.
//  RUN: ctr_counter_on=1; ctr_count_up=1 for UP, 0 for DOWN.
//    remaining decrements each cycle; remaining==1 -> DONE. Exactly N cycles of counter_on.
//  DONE: done=1 for 1 cycle, then IDLE. final_count <= ctr_count on that edge.
//    The counter has already applied the last load/step by then.
//  Latency: accept at cycle T -> LOAD/RUN at T+1 -> done at T+2 (LOAD) or T+1+N (RUN), T+1 (NOP/0).
//  ctr_load and ctr_counter_on are never high together. ctr_data=0 and ctr_count_up=0 outside LOAD/RUN.
//  abort (LOAD/RUN only): it has priority.
//    In the abort cycle, ctr_load and ctr_counter_on are forced 0 combinationally.
//    Next state is DONE with aborted=1. abort is ignored in IDLE and DONE.
//  Arithmetic: the counter wraps modulo 2**NBITS_COUNT. The controller neither saturates nor blocks wrap.
//  cmd_valid held while busy is simply not accepted; the requester must hold it until cmd_ready.
// CONFIGURATION
//  CTRL_WRAP_FLAG_EN defined:
//    Adds output wrap_seen (1 bit), valid with done.
//    wrap_seen=1 if any RUN cycle stepped up from all-ones or down from 0, sampled on ctr_count before the step.
//    Cleared at accept. It is 0 for LOAD and NOP.
//  Not defined: the wrap_seen port and its logic are absent. All other behaviour is identical.
// TESTING
//  1 reset; LOAD data=2 -> ctr_load=1 and ctr_data=2 for 1 cycle at T+1; done at T+2; final_count=2 at T+3.
//  2 from 2, RUN_UP steps=3 (N=2) -> counter_on/count_up high 3 cycles; Count 3,0,1.
//    done at T+4; final_count=1; wrap_seen=1 if enabled.
//  3 RUN_DOWN steps=0 -> counter_on never high; done at T+1; final_count unchanged.
//  4 from 0, RUN_DOWN steps=5, abort on the 3rd RUN cycle -> counter_on high 2 cycles only.
//    Count 3,2; done next cycle with aborted=1; final_count=2.
//  5 reset asserted in the 2nd RUN cycle -> next cycle all ctr_* = 0, busy=0, cmd_ready=1, final_count=0.
//  6 cmd_valid with a new LOAD held during RUN -> cmd_ready=0, no accept.
//    Accepted the cycle after done, then executes normally.

Source files
------------

// File: rtl/contador_seq_ctrl.sv
// -----------------------------------------------------------------------------
// contador_seq_ctrl
//
// Command-driven sequencer for one synchronous up/down counter
// (load / count_up / counter_on / Data_in). It accepts LOAD, RUN_UP-N and
// RUN_DOWN-N commands over a valid/ready handshake. It drives the counter
// control pins and watches the counter's Count output. Completion is reported
// with a one-cycle done pulse and a captured final value. This block is the
// only driver of its counter.
//
// Optional feature: define CTRL_WRAP_FLAG_EN to add the wrap_seen output.
// wrap_seen is 1 if any RUN step went up from all-ones or down from zero.
//
// Ports
//   clk             in   1            single clock, posedge
//   reset           in   1            synchronous, active-high
//   cmd_valid       in   1            command present
//   cmd_ready       out  1            command can be accepted (IDLE only)
//   cmd_op          in   2            00 LOAD, 01 RUN_UP, 10 RUN_DOWN, 11 NOP
//   cmd_data        in   NBITS_COUNT  LOAD value
//   cmd_steps       in   NBITS_STEPS  step count for RUN_UP / RUN_DOWN
//   abort           in   1            cut the current LOAD/RUN short
//   ctr_load        out  1            counter load
//   ctr_count_up    out  1            counter count_up
//   ctr_counter_on  out  1            counter counter_on
//   ctr_data        out  NBITS_COUNT  counter Data_in
//   ctr_count       in   NBITS_COUNT  counter Count
//   busy            out  1            high in LOAD, RUN and DONE
//   done            out  1            one-cycle completion pulse
//   aborted         out  1            with done: command was aborted
//   final_count     out  NBITS_COUNT  Count captured when leaving DONE
//   wrap_seen       out  1            (CTRL_WRAP_FLAG_EN only) with done
// -----------------------------------------------------------------------------
module contador_seq_ctrl #(
    parameter int NBITS_COUNT = 2,
    parameter int NBITS_STEPS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [NBITS_COUNT-1:0] cmd_data,
    input  logic [NBITS_STEPS-1:0] cmd_steps,
    input  logic                   abort,
    output logic                   ctr_load,
    output logic                   ctr_count_up,
    output logic                   ctr_counter_on,
    output logic [NBITS_COUNT-1:0] ctr_data,
    input  logic [NBITS_COUNT-1:0] ctr_count,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [NBITS_COUNT-1:0] final_count
`ifdef CTRL_WRAP_FLAG_EN
    ,
    output logic                   wrap_seen
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_RUN_UP   = 2'b01;
    localparam logic [1:0] OP_RUN_DOWN = 2'b10;

    localparam logic [NBITS_COUNT-1:0] CNT_MAX = {NBITS_COUNT{1'b1}};
    localparam logic [NBITS_STEPS-1:0] STEP_ONE = NBITS_STEPS'(1);

    state_t                 state_q, state_d;
    logic                   up_q, up_d;
    logic [NBITS_COUNT-1:0] data_q, data_d;
    logic [NBITS_STEPS-1:0] remaining_q, remaining_d;
    logic [NBITS_COUNT-1:0] final_count_q, final_count_d;
    logic                   aborted_q, aborted_d;
`ifdef CTRL_WRAP_FLAG_EN
    logic                   wrap_q, wrap_d;
`endif

    // NOTE: state registers use non-blocking assignments so every register
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            up_q          <= 1'b0;
            data_q        <= '0;
            remaining_q   <= '0;
            final_count_q <= '0;
            aborted_q     <= 1'b0;
`ifdef CTRL_WRAP_FLAG_EN
            wrap_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            up_q          <= up_d;
            data_q        <= data_d;
            remaining_q   <= remaining_d;
            final_count_q <= final_count_d;
            aborted_q     <= aborted_d;
`ifdef CTRL_WRAP_FLAG_EN
            wrap_q        <= wrap_d;
`endif
        end
    end

    // NOTE: every signal gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        up_d          = up_q;
        data_d        = data_q;
        remaining_d   = remaining_q;
        final_count_d = final_count_q;
        aborted_d     = aborted_q;
`ifdef CTRL_WRAP_FLAG_EN
        wrap_d        = wrap_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // Accept: latch fields and clear the per-command flags.
                    up_d        = (cmd_op == OP_RUN_UP);
                    data_d      = cmd_data;
                    remaining_d = cmd_steps;
                    aborted_d   = 1'b0;
`ifdef CTRL_WRAP_FLAG_EN
                    wrap_d      = 1'b0;
`endif
                    if (cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if ((cmd_op == OP_RUN_UP || cmd_op == OP_RUN_DOWN) &&
                                 cmd_steps != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        // NOP or zero-step run: the counter is never touched.
                        state_d = ST_DONE;
                    end
                end
            end

            ST_LOAD: begin
                state_d = ST_DONE;
                if (abort) begin
                    aborted_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
`ifdef CTRL_WRAP_FLAG_EN
                    // Count shown here is the value before this cycle's step.
                    if ((up_q && ctr_count == CNT_MAX) || (!up_q && ctr_count == '0)) begin
                        wrap_d = 1'b1;
                    end
`endif
                    remaining_d = remaining_q - STEP_ONE;
                    if (remaining_q == STEP_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // The counter has applied its last load/step by this cycle.
                final_count_d = ctr_count;
                state_d       = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs decode from state only, except that abort gates off
    // the counter enables in the same cycle it is seen.
    always_comb begin
        cmd_ready      = (state_q == ST_IDLE);
        busy           = (state_q != ST_IDLE);
        done           = (state_q == ST_DONE);
        ctr_load       = (state_q == ST_LOAD) && !abort;
        ctr_counter_on = (state_q == ST_RUN) && !abort;
        ctr_count_up   = (state_q == ST_RUN) && up_q;
        ctr_data       = (state_q == ST_LOAD) ? data_q : '0;
        aborted        = (state_q == ST_DONE) && aborted_q;
        final_count    = final_count_q;
    end

`ifdef CTRL_WRAP_FLAG_EN
    assign wrap_seen = (state_q == ST_DONE) && wrap_q;
`endif

    // CNT_MAX is only referenced by the optional wrap logic.
    logic unused_cnt_max;
    assign unused_cnt_max = ^CNT_MAX;

endmodule

// File: tb/tb_contador_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_contador_seq_ctrl
//
// Drives commands into contador_seq_ctrl, which controls a behavioural
// up/down counter kept here. For every accepted command, a reference model
// computes the expected done cycle, the expected aborted and wrap flags, the
// number of load and counter_on cycles, and the final count. These are
// computed from plain modular arithmetic on the counter value and pushed into
// a scoreboard queue. A separate monitor pops an entry on each done pulse and
// compares the DUT against it.
// -----------------------------------------------------------------------------
module tb_contador_seq_ctrl;

    localparam int NB  = 2;
    localparam int NS  = 4;
    localparam int MOD = 1 << NB;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_RUN_UP   = 2'b01;
    localparam logic [1:0] OP_RUN_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP      = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [NB-1:0] cmd_data;
    logic [NS-1:0] cmd_steps;
    logic          abort;
    logic          ctr_load;
    logic          ctr_count_up;
    logic          ctr_counter_on;
    logic [NB-1:0] ctr_data;
    logic [NB-1:0] ctr_count = '0;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [NB-1:0] final_count;
`ifdef CTRL_WRAP_FLAG_EN
    logic          wrap_seen;
`endif

    contador_seq_ctrl #(.NBITS_COUNT(NB), .NBITS_STEPS(NS)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .cmd_steps      (cmd_steps),
        .abort          (abort),
        .ctr_load       (ctr_load),
        .ctr_count_up   (ctr_count_up),
        .ctr_counter_on (ctr_counter_on),
        .ctr_data       (ctr_data),
        .ctr_count      (ctr_count),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .final_count    (final_count)
`ifdef CTRL_WRAP_FLAG_EN
        ,
        .wrap_seen      (wrap_seen)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // The counter being controlled. It has no reset and keeps its value.
    always @(posedge clk) begin
        if (ctr_load)
            ctr_count <= ctr_data;
        else if (ctr_counter_on)
            ctr_count <= ctr_count_up ? ctr_count + 1'b1 : ctr_count - 1'b1;
    end

    typedef struct {
        int            done_cyc;
        logic [NB-1:0] fin;
        logic [NB-1:0] ldata;
        bit            abrt;
        bit            wrap;
        int            loads;
        int            ons;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_val = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one command. abort_at = k drives abort in busy cycle k. It is
    // effective only when k is within the LOAD/RUN length. When k is one past
    // that length, abort lands in the DONE cycle and must be ignored. If track
    // is 0, no scoreboard entry is pushed and the model is left untouched.
    task automatic issue_cmd(input logic [1:0] op, input int data, input int steps,
                             input int abort_at, input bit track, output int acc);
        int   waited;
        int   len;
        bit   eff;
        exp_t e;
        waited    = 0;
        acc       = -1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data[NB-1:0];
        cmd_steps = steps[NS-1:0];
        @(negedge clk);
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc       = cyc;
        cmd_valid = 1'b0;

        if (op == OP_LOAD)
            len = 1;
        else if ((op == OP_RUN_UP || op == OP_RUN_DOWN) && steps > 0)
            len = steps;
        else
            len = 0;
        eff = (abort_at >= 1) && (abort_at <= len);

        if (track) begin
            e.done_cyc = acc + (eff ? abort_at : len);
            e.abrt     = eff;
            e.ldata    = data[NB-1:0];
            e.loads    = 0;
            e.ons      = 0;
            e.wrap     = 1'b0;
            if (op == OP_LOAD) begin
                if (!eff) begin
                    e.loads   = 1;
                    model_val = data % MOD;
                end
            end else if (len > 0) begin
                e.ons = eff ? abort_at - 1 : steps;
                if (op == OP_RUN_UP) begin
                    e.wrap    = (model_val + e.ons) >= MOD;
                    model_val = (model_val + e.ons) % MOD;
                end else begin
                    e.wrap    = e.ons > model_val;
                    model_val = (((model_val - e.ons) % MOD) + MOD) % MOD;
                end
            end
            e.fin = model_val[NB-1:0];
            sb.push_back(e);
        end

        if (abort_at >= 1 && abort_at <= len + 1) begin
            repeat (abort_at - 1) begin
                @(posedge clk);
                #1;
            end
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
    endtask

    // Monitor: per-cycle invariants plus the scoreboard pop on each done pulse.
    int on_cnt   = 0;
    int load_cnt = 0;
    initial begin
        bit            pend;
        logic [NB-1:0] pend_fin;
        exp_t          e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                on_cnt   = 0;
                load_cnt = 0;
                pend     = 1'b0;
            end else begin
                check("load_on_exclusive", 32'(ctr_load & ctr_counter_on), 32'd0);
                check("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
                if (!busy) begin
                    check("idle_ctr_data", 32'(ctr_data), 32'd0);
                    check("idle_count_up", 32'(ctr_count_up), 32'd0);
                end
                if (ctr_counter_on) on_cnt++;
                if (ctr_load) begin
                    load_cnt++;
                    if (sb.size() > 0) check("load_data", 32'(ctr_data), 32'(sb[0].ldata));
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                        check("aborted", 32'(aborted), 32'(e.abrt));
                        check("load_cycles", 32'(load_cnt), 32'(e.loads));
                        check("counter_on_cycles", 32'(on_cnt), 32'(e.ons));
`ifdef CTRL_WRAP_FLAG_EN
                        check("wrap_seen", 32'(wrap_seen), 32'(e.wrap));
`endif
                        pend_fin = e.fin;
                        pend     = 1'b1;
                    end
                    on_cnt   = 0;
                    load_cnt = 0;
                end else begin
                    check("aborted_without_done", 32'(aborted), 32'd0);
                    if (pend) begin
                        check("final_count", 32'(final_count), 32'(pend_fin));
                        pend = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1;
        int acc2;
        int dummy;
        int waited;
        int op;
        int ab;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        cmd_steps = '0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state is visible while reset is still held.
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_final_count", 32'(final_count), 32'd0);
        check("rst_ctr_ctrl", 32'({ctr_load, ctr_count_up, ctr_counter_on}), 32'd0);
        reset = 1'b0;

        // Directed cases.
        issue_cmd(OP_LOAD, 2, 0, 0, 1'b1, dummy);      // load 2
        issue_cmd(OP_RUN_UP, 0, 3, 0, 1'b1, dummy);    // 2 -> 3,0,1
        issue_cmd(OP_RUN_DOWN, 0, 0, 0, 1'b1, dummy);  // zero steps
        issue_cmd(OP_LOAD, 0, 0, 0, 1'b1, dummy);
        issue_cmd(OP_RUN_DOWN, 0, 5, 3, 1'b1, dummy);  // abort in RUN cycle 3
        issue_cmd(OP_LOAD, 3, 0, 1, 1'b1, dummy);      // aborted LOAD
        issue_cmd(OP_NOP, 0, 0, 1, 1'b1, dummy);       // abort in DONE is ignored

        // Reset during the second RUN cycle. Two steps reach the counter.
        waited = 0;
        while (sb.size() > 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        issue_cmd(OP_RUN_DOWN, 0, 5, 0, 1'b0, acc1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_ctr_ctrl", 32'({ctr_load, ctr_count_up, ctr_counter_on}), 32'd0);
        check("rstmid_ctr_data", 32'(ctr_data), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rstmid_final_count", 32'(final_count), 32'd0);
        model_val = (((model_val - 2) % MOD) + MOD) % MOD;
        @(posedge clk);
        #1;
        issue_cmd(OP_NOP, 0, 0, 0, 1'b1, dummy);

        // A LOAD held during a RUN is accepted in the cycle after done.
        issue_cmd(OP_RUN_UP, 0, 4, 0, 1'b1, acc1);
        issue_cmd(OP_LOAD, 1, 0, 0, 1'b1, acc2);
        check("held_accept_cycle", 32'(acc2), 32'(acc1 + 6));

        // Randomized commands.
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 3);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
            issue_cmd(op[1:0], $urandom_range(0, MOD - 1), $urandom_range(0, 15), ab, 1'b1, dummy);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        waited = 0;
        while (sb.size() > 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
